// File: rtl/master_arb_w_pkg.sv
// Shared arbiter definitions for the write channel: FSM encodings, grant
// constants (also used by the request-side logic) and a small index helper.
package master_arb_w_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam logic [2:0] GRANT_NONE = 3'b000;
  localparam logic [2:0] GNT_M0     = 3'b001;
  localparam logic [2:0] GNT_M1     = 3'b010;
  localparam logic [2:0] GNT_M2     = 3'b100;

  localparam logic [1:0] GID_NONE   = 2'd3;

  // Pointer reset value: master 0 is searched first after reset.
  localparam logic [1:0] PTR_RESET  = 2'd2;

  // Next master index in the ring 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // One-hot mask for a master index (index 3 yields no bit).
  function automatic logic [2:0] idx_mask(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/master_arb_w_rr_pick3.sv
// Combinational 3-way winner selection. With rr_en set, the search starts just
// after ptr and wraps 2 -> 0; otherwise the lowest requesting index wins.
module rr_pick3
  import master_arb_w_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic       rr_en,
  output logic [2:0] gnt_oh,
  output logic [1:0] gnt_id
);

  logic [1:0] start_idx;
  logic [1:0] cand [3];
  logic       found;

  // Build the search order and keep the first requester in that order.
  always_comb begin
    start_idx = rr_en ? next_idx(ptr) : 2'd0;
    cand[0]   = start_idx;
    cand[1]   = next_idx(start_idx);
    cand[2]   = next_idx(cand[1]);
    gnt_id    = GID_NONE;
    found     = 1'b0;
    // Walk backwards so the earliest candidate overwrites later ones.
    for (int k = 2; k >= 0; k--) begin
      if (|(req & idx_mask(cand[k]))) begin
        gnt_id = cand[k];
        found  = 1'b1;
      end
    end
  end

  // Expand the winning index to the one-hot grant.
  for (genvar gi = 0; gi < 3; gi++) begin : g_oh
    assign gnt_oh[gi] = found && (gnt_id == 2'(gi));
  end

endmodule

// File: rtl/master_arb_w.sv
// Write-channel arbiter for the 3-master interconnect. Issues a one-hot grant
// from IDLE, holds it through the whole transaction and drops it on the
// transaction-done strobe. A watchdog flags over-long holds without revoking.
module master_arb_w
  import master_arb_w_pkg::*;
#(
  parameter int RR_EN        = 1,
  parameter int MAX_HOLD_CYC = 256
) (
  input  logic       sys_clk,
  input  logic       sys_rstn,
  input  logic       wr_req_0,
  input  logic       wr_req_1,
  input  logic       wr_req_2,
  input  logic       wr_state_refre,
  output logic [2:0] wr_grant,
  output logic [1:0] wr_grant_id,
  output logic       wr_busy,
  output logic       wr_timeout
);

  localparam int              CNT_W      = (MAX_HOLD_CYC > 0) ? $clog2(MAX_HOLD_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD_CYC);
  localparam logic            WD_EN      = (MAX_HOLD_CYC > 0);
  localparam logic            RR_ON      = (RR_EN != 0);

  arb_state_t       state_reg, state_next;
  logic [2:0]       grant_reg, grant_next;
  logic [1:0]       gid_reg, gid_next;
  logic             busy_reg, busy_next;
  logic             timeout_reg, timeout_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0] hold_reg, hold_next;
  logic [CNT_W-1:0] hold_inc;

  logic [2:0]       req_vec;
  logic [2:0]       pick_oh;
  logic [1:0]       pick_id;

  assign req_vec = {wr_req_2, wr_req_1, wr_req_0};

  rr_pick3 u_pick (
    .req    (req_vec),
    .ptr    (ptr_reg),
    .rr_en  (RR_ON),
    .gnt_oh (pick_oh),
    .gnt_id (pick_id)
  );

  // Saturating increment of the hold counter.
  assign hold_inc = (hold_reg == CNT_SAT) ? hold_reg : hold_reg + CNT_W'(1);

  // Next-state and next-output decode for the grant FSM.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    gid_next     = gid_reg;
    ptr_next     = ptr_reg;
    hold_next    = hold_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      ARB_IDLE: begin
        // A done strobe seen here is stale and deliberately ignored.
        if (|req_vec) begin
          state_next   = ARB_GRANT;
          grant_next   = pick_oh;
          gid_next     = pick_id;
          hold_next    = '0;
          timeout_next = 1'b0;
          if (RR_ON) begin
            ptr_next = pick_id;
          end
        end
      end
      ARB_GRANT: begin
        // Release wins over any new request; arbitration resumes from IDLE.
        if (wr_state_refre) begin
          state_next   = ARB_IDLE;
          grant_next   = GRANT_NONE;
          gid_next     = GID_NONE;
          hold_next    = '0;
          timeout_next = 1'b0;
        end else begin
          hold_next = hold_inc;
          if (WD_EN && (hold_inc >= HOLD_LIMIT)) begin
            timeout_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = GRANT_NONE;
        gid_next   = GID_NONE;
      end
    endcase
    busy_next = |grant_next;
  end

  // State and registered outputs; reset is asynchronous.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_reg   <= ARB_IDLE;
      grant_reg   <= GRANT_NONE;
      gid_reg     <= GID_NONE;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      ptr_reg     <= PTR_RESET;
      hold_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      gid_reg     <= gid_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
      ptr_reg     <= ptr_next;
      hold_reg    <= hold_next;
    end
  end

  assign wr_grant    = grant_reg;
  assign wr_grant_id = gid_reg;
  assign wr_busy     = busy_reg;
  assign wr_timeout  = timeout_reg;

endmodule

// File: tb/tb_master_arb_w.sv
// Directed bench for master_arb_w: a round-robin instance (a) and a
// fixed-priority instance (b), both with a 4-cycle watchdog. Expected grants
// are queued as stimulus is applied and popped when a grant appears.
module tb_master_arb_w;

  logic       sys_clk = 1'b0;
  logic       sys_rstn = 1'b0;
  logic [2:0] req_a, req_b;
  logic       refre_a, refre_b;
  logic [2:0] grant_a, grant_b;
  logic [1:0] gid_a, gid_b;
  logic       busy_a, busy_b, tmo_a, tmo_b;

  typedef struct {
    logic [2:0] grant;
    logic [1:0] id;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  master_arb_w #(.RR_EN(1), .MAX_HOLD_CYC(4)) u_rr (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .wr_req_0(req_a[0]), .wr_req_1(req_a[1]), .wr_req_2(req_a[2]),
    .wr_state_refre(refre_a),
    .wr_grant(grant_a), .wr_grant_id(gid_a), .wr_busy(busy_a), .wr_timeout(tmo_a)
  );

  master_arb_w #(.RR_EN(0), .MAX_HOLD_CYC(4)) u_fp (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .wr_req_0(req_b[0]), .wr_req_1(req_b[1]), .wr_req_2(req_b[2]),
    .wr_state_refre(refre_b),
    .wr_grant(grant_b), .wr_grant_id(gid_b), .wr_busy(busy_b), .wr_timeout(tmo_b)
  );

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] cur_grant(input bit sel);
    return sel ? grant_b : grant_a;
  endfunction

  function automatic logic [1:0] cur_gid(input bit sel);
    return sel ? gid_b : gid_a;
  endfunction

  function automatic logic cur_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic cur_tmo(input bit sel);
    return sel ? tmo_b : tmo_a;
  endfunction

  task automatic push(input logic [2:0] g, input logic [1:0] id);
    exp_t e;
    e.grant = g;
    e.id    = id;
    e.lat   = 1;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input bit sel, input string tag);
    check({tag, "_grant"}, 32'(cur_grant(sel)), 32'h0);
    check({tag, "_id"},    32'(cur_gid(sel)),   32'h3);
    check({tag, "_busy"},  32'(cur_busy(sel)),  32'h0);
    check({tag, "_tmo"},   32'(cur_tmo(sel)),   32'h0);
  endtask

  // Wait (bounded) for the next grant and compare it against the queue head.
  task automatic wait_grant(input bit sel, input string tag, output logic [2:0] g);
    exp_t e;
    int   n;
    n = 0;
    while (cur_grant(sel) === 3'b000 && n < 20) begin
      tick();
      n++;
    end
    if (exp_q.size() == 0) begin
      $display("FAIL %s_sb observed=empty expected=entry", tag);
      $fatal(1, "scoreboard underflow");
    end
    e = exp_q.pop_front();
    g = e.grant;
    check({tag, "_grant"}, 32'(cur_grant(sel)), 32'(e.grant));
    check({tag, "_id"},    32'(cur_gid(sel)),   32'(e.id));
    check({tag, "_busy"},  32'(cur_busy(sel)),  32'h1);
    check({tag, "_lat"},   32'(n),              32'(e.lat));
    $display("txn %s: grant=%b id=%0d after %0d cycle(s)", tag, cur_grant(sel), cur_gid(sel), n);
  endtask

  task automatic hold(input bit sel, input string tag, input int cycles, input logic [2:0] g);
    for (int k = 0; k < cycles; k++) begin
      tick();
      check({tag, "_grant"}, 32'(cur_grant(sel)), 32'(g));
    end
  endtask

  task automatic release_grant(input bit sel, input string tag);
    if (sel) refre_b = 1'b1; else refre_a = 1'b1;
    tick();
    refre_a = 1'b0;
    refre_b = 1'b0;
    check_idle(sel, tag);
  endtask

  initial begin
    logic [2:0] g;
    req_a = 3'b000; req_b = 3'b000;
    refre_a = 1'b0; refre_b = 1'b0;
    repeat (3) tick();
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    sys_rstn = 1'b1;
    tick();
    check_idle(0, "rst_rel_a");

    // Round-robin rotation with all masters requesting.
    req_a = 3'b111;
    push(3'b001, 2'd0); push(3'b010, 2'd1); push(3'b100, 2'd2); push(3'b001, 2'd0);
    for (int i = 0; i < 4; i++) begin
      wait_grant(0, "t1_rr", g);
      hold(0, "t1_hold", 2, g);
      if (i < 3) release_grant(0, "t1_rel");
    end

    // Grant holds after the requester drops; release and new request together.
    req_a = 3'b000;
    hold(0, "t3_drop_hold", 2, 3'b001);
    req_a = 3'b100;
    push(3'b100, 2'd2);
    release_grant(0, "t3_rel");
    wait_grant(0, "t3_new", g);
    req_a = 3'b000;
    release_grant(0, "t3_rel2");

    // Done strobe while idle must not disturb anything.
    refre_a = 1'b1;
    tick();
    refre_a = 1'b0;
    check_idle(0, "t4_idle_strobe");
    tick();
    check_idle(0, "t4_idle_after");

    // Watchdog: flag appears once four full grant cycles have elapsed
    // (cycle 4 counting the first grant cycle as 0) and the grant is kept.
    req_a = 3'b001;
    push(3'b001, 2'd0);
    wait_grant(0, "t5_wd", g);
    check("t5_tmo_0", 32'(tmo_a), 32'h0);
    req_a = 3'b000;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("t5_grant_c%0d", k), 32'(grant_a), 32'h1);
      check($sformatf("t5_tmo_c%0d", k),   32'(tmo_a),   32'(k >= 4));
      check($sformatf("t5_busy_c%0d", k),  32'(busy_a),  32'h1);
    end
    release_grant(0, "t5_rel");

    // Asynchronous reset mid-grant with the watchdog flag already set.
    req_a = 3'b010;
    push(3'b010, 2'd1);
    wait_grant(0, "t6_pre", g);
    req_a = 3'b110;
    hold(0, "t6_hold", 5, 3'b010);
    check("t6_tmo_set", 32'(tmo_a), 32'h1);
    #2;
    sys_rstn = 1'b0;
    #1;
    check_idle(0, "t6_async");
    check_idle(1, "t6_async_b");
    #1;
    sys_rstn = 1'b1;
    push(3'b010, 2'd1);
    wait_grant(0, "t6_post", g);
    req_a = 3'b000;
    release_grant(0, "t6_rel");

    // Fixed priority: master 1 keeps winning over master 2 until it drops.
    req_b = 3'b110;
    for (int i = 0; i < 3; i++) begin
      push(3'b010, 2'd1);
      wait_grant(1, "t2_fp", g);
      hold(1, "t2_hold", 1, g);
      release_grant(1, "t2_rel");
    end
    push(3'b010, 2'd1);
    wait_grant(1, "t2_fp_last", g);
    req_b = 3'b100;
    hold(1, "t2_hold_last", 1, g);
    push(3'b100, 2'd2);
    release_grant(1, "t2_rel_last");
    wait_grant(1, "t2_m2", g);
    req_b = 3'b000;
    release_grant(1, "t2_rel_m2");

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
